// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stim_pkg
//  Description : Shared types and constants for the stimulus sequence player:
//                FSM state encoding, LFSR tap mask, default LFSR seed and the
//                LFSR step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package stim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_PAUSE = 3'd2,
      ST_RAND  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form:
   // feedback is the XOR of bits 0, 2, 3 and 5, injected at bit 15.
   localparam logic [15:0] LFSR_TAPS         = 16'h002D;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/stim_vec_ram.sv
`default_nettype none
// ============================================================================
//  Module      : stim_vec_ram
//  Description : Simple dual-port vector memory, one write port and one
//                synchronous read port with a single cycle of latency. The
//                read register holds its value while rd_en_i is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_vec_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Storage is deliberately not reset so contents survive rst_n pulses.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/stim_seq_player.sv
`default_nettype none
// ============================================================================
//  Module      : stim_seq_player
//  Description : Replays stored {rst,in} vectors into an FSM under test, one
//                per cycle, with pause/abort control. Optional macro
//                STIM_LFSR_EN adds a pseudo-random tail (RAND state) driven
//                by a 16-bit LFSR after the stored vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_seq_player
   import stim_pkg::*;
#(
   parameter int IN_LEN = 7,
   parameter int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [IN_LEN:0]   wr_data,
   input  logic [ADDR_W:0]   seq_len,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
`ifdef STIM_LFSR_EN
   input  logic [15:0]       lfsr_seed,
   input  logic [15:0]       lfsr_cycles,
`endif
   output logic              dut_rst,
   output logic [IN_LEN-1:0] dut_in,
   output logic              vec_valid,
   output logic [ADDR_W:0]   vec_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0] C_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_ONE_IDX = (ADDR_W+1)'(1);

   state_e              state_q, state_d;
   logic                resume_rand_q, resume_rand_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
   logic [ADDR_W:0]     pres_cnt_q, pres_cnt_d;
   logic                rd_valid_q, rd_valid_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [15:0]         cycles_q, cycles_d;
   logic [15:0]         rand_cnt_q, rand_cnt_d;
   logic                dut_rst_q, dut_rst_d;
   logic [IN_LEN-1:0]   dut_in_q, dut_in_d;
   logic                vec_valid_q, vec_valid_d;
   logic [ADDR_W:0]     vec_idx_q, vec_idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                w_rd_en;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [IN_LEN:0]     w_rd_data;
   logic                w_wr_en;
   logic [ADDR_W:0]     w_len_clamp;
   logic [15:0]         w_seed;
   logic [15:0]         w_cycles;

`ifdef STIM_LFSR_EN
   assign w_seed   = (lfsr_seed == 16'h0000) ? LFSR_DEFAULT_SEED : lfsr_seed;
   assign w_cycles = lfsr_cycles;
`else
   assign w_seed   = LFSR_DEFAULT_SEED;
   assign w_cycles = 16'h0000;
`endif

   // Writes are only accepted while no playback is in progress.
   assign w_wr_en     = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign w_rd_addr   = issue_cnt_q[ADDR_W-1:0];
   assign w_len_clamp = (seq_len > C_DEPTH) ? C_DEPTH : seq_len;

   stim_vec_ram #(
      .WIDTH  (IN_LEN + 1),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (w_wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_en_i   (w_rd_en),
      .rd_addr_i (w_rd_addr),
      .rd_data_o (w_rd_data)
   );

   // Next-state logic: reads run one cycle ahead of presentation; the RAM
   // read register doubles as the one-entry buffer that survives a pause.
   always_comb begin
      state_d       = state_q;
      resume_rand_d = resume_rand_q;
      len_d         = len_q;
      issue_cnt_d   = issue_cnt_q;
      pres_cnt_d    = pres_cnt_q;
      rd_valid_d    = rd_valid_q;
      lfsr_d        = lfsr_q;
      cycles_d      = cycles_q;
      rand_cnt_d    = rand_cnt_q;
      dut_rst_d     = dut_rst_q;
      dut_in_d      = dut_in_q;
      vec_valid_d   = 1'b0;
      vec_idx_d     = vec_idx_q;
      w_rd_en       = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               len_d         = w_len_clamp;
               issue_cnt_d   = '0;
               pres_cnt_d    = '0;
               rd_valid_d    = 1'b0;
               lfsr_d        = w_seed;
               cycles_d      = w_cycles;
               rand_cnt_d    = 16'h0000;
               resume_rand_d = 1'b0;
               if (w_len_clamp != '0) begin
                  state_d = ST_PLAY;
               end else if (w_cycles != 16'h0000) begin
                  state_d = ST_RAND;
               end else begin
                  state_d   = ST_DONE;
                  dut_rst_d = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (pause) begin
               state_d       = ST_PAUSE;
               resume_rand_d = 1'b0;
            end else if (pres_cnt_q == len_q) begin
               state_d   = ST_DONE;
               dut_rst_d = 1'b1;
            end else begin
               if (rd_valid_q) begin
                  dut_rst_d   = w_rd_data[IN_LEN];
                  dut_in_d    = w_rd_data[IN_LEN-1:0];
                  vec_valid_d = 1'b1;
                  vec_idx_d   = pres_cnt_q;
                  pres_cnt_d  = pres_cnt_q + C_ONE_IDX;
                  // Hand straight over to the random tail so it follows
                  // the last stored vector without a gap.
                  if ((pres_cnt_q == len_q - C_ONE_IDX) && (cycles_q != 16'h0000)) begin
                     state_d = ST_RAND;
                  end
               end
               if (issue_cnt_q < len_q) begin
                  w_rd_en     = 1'b1;
                  issue_cnt_d = issue_cnt_q + C_ONE_IDX;
                  rd_valid_d  = 1'b1;
               end else begin
                  rd_valid_d  = 1'b0;
               end
            end
         end
         ST_RAND: begin
            if (pause) begin
               state_d       = ST_PAUSE;
               resume_rand_d = 1'b1;
            end else if (rand_cnt_q == cycles_q) begin
               state_d   = ST_DONE;
               dut_rst_d = 1'b1;
            end else begin
               dut_rst_d   = 1'b0;
               dut_in_d    = IN_LEN'(lfsr_q);
               vec_valid_d = 1'b1;
               vec_idx_d   = pres_cnt_q;
               pres_cnt_d  = pres_cnt_q + C_ONE_IDX;
               lfsr_d      = lfsr_step(lfsr_q);
               rand_cnt_d  = rand_cnt_q + 16'h0001;
            end
         end
         ST_PAUSE: begin
            if (!pause) begin
               state_d = resume_rand_q ? ST_RAND : ST_PLAY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_d     = ST_IDLE;
         dut_rst_d   = 1'b1;
         dut_in_d    = '0;
         vec_valid_d = 1'b0;
         vec_idx_d   = '0;
         rd_valid_d  = 1'b0;
         w_rd_en     = 1'b0;
      end

      busy_d = (state_d == ST_PLAY) || (state_d == ST_PAUSE) || (state_d == ST_RAND);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs; reset returns to IDLE immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         resume_rand_q <= 1'b0;
         len_q         <= '0;
         issue_cnt_q   <= '0;
         pres_cnt_q    <= '0;
         rd_valid_q    <= 1'b0;
         lfsr_q        <= LFSR_DEFAULT_SEED;
         cycles_q      <= 16'h0000;
         rand_cnt_q    <= 16'h0000;
         dut_rst_q     <= 1'b1;
         dut_in_q      <= '0;
         vec_valid_q   <= 1'b0;
         vec_idx_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         resume_rand_q <= resume_rand_d;
         len_q         <= len_d;
         issue_cnt_q   <= issue_cnt_d;
         pres_cnt_q    <= pres_cnt_d;
         rd_valid_q    <= rd_valid_d;
         lfsr_q        <= lfsr_d;
         cycles_q      <= cycles_d;
         rand_cnt_q    <= rand_cnt_d;
         dut_rst_q     <= dut_rst_d;
         dut_in_q      <= dut_in_d;
         vec_valid_q   <= vec_valid_d;
         vec_idx_q     <= vec_idx_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign dut_rst   = dut_rst_q;
   assign dut_in    = dut_in_q;
   assign vec_valid = vec_valid_q;
   assign vec_idx   = vec_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stim_seq_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stim_seq_player
//  Description : Self-checking bench for stim_seq_player. Expected playback
//                is the list of stored vectors held in a bench-side memory
//                image, optionally followed by an LFSR tail.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_seq_player;

   localparam int IN_LEN = 7;
   localparam int DEPTH  = 16;
   localparam int AW     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [IN_LEN:0]   wr_data;
   logic [AW:0]       seq_len;
   logic              start;
   logic              pause;
   logic              abort;
`ifdef STIM_LFSR_EN
   logic [15:0]       lfsr_seed;
   logic [15:0]       lfsr_cycles;
`endif
   logic              dut_rst;
   logic [IN_LEN-1:0] dut_in;
   logic              vec_valid;
   logic [AW:0]       vec_idx;
   logic              busy;
   logic              done;

   stim_seq_player #(
      .IN_LEN (IN_LEN),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .seq_len     (seq_len),
      .start       (start),
      .pause       (pause),
      .abort       (abort),
`ifdef STIM_LFSR_EN
      .lfsr_seed   (lfsr_seed),
      .lfsr_cycles (lfsr_cycles),
`endif
      .dut_rst     (dut_rst),
      .dut_in      (dut_in),
      .vec_valid   (vec_valid),
      .vec_idx     (vec_idx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  ref_mem [DEPTH];
   logic [12:0] got_q [$];
   int          timed_out;
   int          pause_viol;

   task automatic mem_write(input int a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic do_start(input int len);
      seq_len = 5'(len);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   // Runs the clock until done, capturing every presented vector.
   task automatic play_collect(input int budget, input int pause_pct);
      got_q.delete();
      timed_out  = 1;
      pause_viol = 0;
      for (int c = 0; c < budget; c++) begin
         pause = ($urandom_range(99) < pause_pct);
         @(posedge clk); #1;
         if (vec_valid) got_q.push_back({dut_rst, dut_in, vec_idx});
         if (pause && vec_valid) pause_viol++;
         if (done) begin
            timed_out = 0;
            break;
         end
      end
      pause = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({dut_rst, dut_in, vec_valid, vec_idx, busy, done} !== {1'b1, 7'h00, 1'b0, 5'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", {dut_rst, dut_in, vec_valid, vec_idx, busy, done},
                  {1'b1, 7'h00, 1'b0, 5'd0, 1'b0, 1'b0});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, done, vec_valid, dut_rst} !== 4'b0001) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b expected 0001", {busy, done, vec_valid, dut_rst});
      end
   endtask

   task automatic test_basic;
      logic [12:0] exp_v [3];
      mem_write(0, 8'h80);
      mem_write(1, 8'h7F);
      mem_write(2, 8'h15);
      exp_v[0] = {8'h80, 5'd0};
      exp_v[1] = {8'h7F, 5'd1};
      exp_v[2] = {8'h15, 5'd2};
      do_start(3);
      n_vec++;
      if ({vec_valid, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL basic_edge_k: valid/busy got %b expected 01", {vec_valid, busy});
      end
      @(posedge clk); #1;
      n_vec++;
      if (vec_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_edge_k1: vec_valid got %b expected 0", vec_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({vec_valid, dut_rst, dut_in, vec_idx} !== {1'b1, exp_v[i]}) begin
            n_err++;
            $display("FAIL basic_vec%0d: got %h expected %h", i, {vec_valid, dut_rst, dut_in, vec_idx}, {1'b1, exp_v[i]});
         end
      end
      @(posedge clk); #1;
      n_vec++;
      if ({done, busy, dut_rst, vec_valid, dut_in} !== {1'b1, 1'b0, 1'b1, 1'b0, 7'h15}) begin
         n_err++;
         $display("FAIL basic_done: got %b expected %b", {done, busy, dut_rst, vec_valid, dut_in},
                  {1'b1, 1'b0, 1'b1, 1'b0, 7'h15});
      end
   endtask

   task automatic test_random_play;
      for (int i = 0; i < DEPTH; i++) mem_write(i, 8'($urandom));
      for (int it = 0; it < 6; it++) begin
         int len;
         int n_exp;
         repeat ($urandom_range(3)) mem_write($urandom_range(DEPTH-1), 8'($urandom));
         len   = (it == 0) ? DEPTH + 7 : $urandom_range(1, DEPTH + 6);
         n_exp = (len > DEPTH) ? DEPTH : len;
         do_start(len);
         play_collect(300, 25);
         n_vec++;
         if (timed_out != 0 || got_q.size() != n_exp) begin
            n_err++;
            $display("FAIL rand%0d_count: got %0d vectors (timeout %0d) expected %0d", it, got_q.size(), timed_out, n_exp);
         end
         n_vec++;
         if (pause_viol != 0) begin
            n_err++;
            $display("FAIL rand%0d_pause: vec_valid during pause %0d times expected 0", it, pause_viol);
         end
         for (int k = 0; k < n_exp && k < got_q.size(); k++) begin
            n_vec++;
            if (got_q[k] !== {ref_mem[k], 5'(k)}) begin
               n_err++;
               $display("FAIL rand%0d_vec%0d: got %h expected %h", it, k, got_q[k], {ref_mem[k], 5'(k)});
            end
         end
      end
   endtask

   task automatic test_pause;
      int found;
      do_start(4);
      found = 0;
      for (int c = 0; c < 10 && found == 0; c++) begin
         @(posedge clk); #1;
         if (vec_valid && vec_idx == 5'd1) found = 1;
      end
      n_vec++;
      if (found == 0) begin
         n_err++;
         $display("FAIL pause_reach_v1: vector 1 seen %0d expected 1", found);
      end
      pause = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({vec_valid, dut_rst, dut_in, vec_idx} !== {1'b0, ref_mem[1], 5'd1}) begin
            n_err++;
            $display("FAIL pause_hold%0d: got %h expected %h", c, {vec_valid, dut_rst, dut_in, vec_idx}, {1'b0, ref_mem[1], 5'd1});
         end
      end
      pause = 1'b0;
      found = 0;
      for (int c = 0; c < 5 && found == 0; c++) begin
         @(posedge clk); #1;
         if (vec_valid) found = 1;
      end
      n_vec++;
      if (found == 0 || {dut_rst, dut_in, vec_idx} !== {ref_mem[2], 5'd2}) begin
         n_err++;
         $display("FAIL pause_resume_v2: got %h (seen %0d) expected %h", {dut_rst, dut_in, vec_idx}, found, {ref_mem[2], 5'd2});
      end
      @(posedge clk); #1;
      n_vec++;
      if ({vec_valid, dut_rst, dut_in, vec_idx} !== {1'b1, ref_mem[3], 5'd3}) begin
         n_err++;
         $display("FAIL pause_resume_v3: got %h expected %h", {vec_valid, dut_rst, dut_in, vec_idx}, {1'b1, ref_mem[3], 5'd3});
      end
      @(posedge clk); #1;
      n_vec++;
      if ({done, vec_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL pause_done: done/valid got %b expected 10", {done, vec_valid});
      end
   endtask

   task automatic test_abort;
      int found;
      int stray;
      do_start(8);
      found = 0;
      for (int c = 0; c < 12 && found == 0; c++) begin
         @(posedge clk); #1;
         if (vec_valid && vec_idx == 5'd2) found = 1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_vec++;
      if (found == 0 || {dut_rst, dut_in, vec_valid, busy, done} !== {1'b1, 7'h00, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL abort_idle: got %b (seen %0d) expected %b", {dut_rst, dut_in, vec_valid, busy, done}, found,
                  {1'b1, 7'h00, 1'b0, 1'b0, 1'b0});
      end
      stray = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (vec_valid || busy) stray++;
      end
      n_vec++;
      if (stray != 0) begin
         n_err++;
         $display("FAIL abort_stays_idle: activity cycles %0d expected 0", stray);
      end
   endtask

   task automatic test_async_reset;
      int found;
      do_start(8);
      found = 0;
      for (int c = 0; c < 12 && found == 0; c++) begin
         @(posedge clk); #1;
         if (vec_valid && vec_idx == 5'd3) found = 1;
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (found == 0 || {dut_rst, dut_in, vec_valid, vec_idx, busy, done} !== {1'b1, 7'h00, 1'b0, 5'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL async_reset: got %b (seen %0d) expected %b", {dut_rst, dut_in, vec_valid, vec_idx, busy, done}, found,
                  {1'b1, 7'h00, 1'b0, 5'd0, 1'b0, 1'b0});
      end
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, vec_valid, done} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_no_resume: busy/valid/done got %b expected 000", {busy, vec_valid, done});
      end
      do_start(8);
      play_collect(100, 0);
      n_vec++;
      if (timed_out != 0 || got_q.size() != 8) begin
         n_err++;
         $display("FAIL reset_replay_count: got %0d (timeout %0d) expected 8", got_q.size(), timed_out);
      end
      for (int k = 0; k < 8 && k < got_q.size(); k++) begin
         n_vec++;
         if (got_q[k] !== {ref_mem[k], 5'(k)}) begin
            n_err++;
            $display("FAIL reset_replay_vec%0d: got %h expected %h", k, got_q[k], {ref_mem[k], 5'(k)});
         end
      end
   endtask

   task automatic test_zero_len_and_busy_write;
      int seen_done;
      int n_valid;
      do_start(0);
      seen_done = 0;
      n_valid   = 0;
      if (vec_valid) n_valid++;
      if (done) seen_done = 1;
      repeat (3) begin
         @(posedge clk); #1;
         if (vec_valid) n_valid++;
         if (done) seen_done = 1;
      end
      n_vec++;
      if (seen_done != 1 || n_valid != 0) begin
         n_err++;
         $display("FAIL zero_len: done seen %0d valid count %0d expected 1 and 0", seen_done, n_valid);
      end
      do_start(8);
      got_q.delete();
      timed_out = 1;
      for (int c = 0; c < 60; c++) begin
         wr_en   = 1'b1;
         wr_addr = AW'($urandom_range(7));
         wr_data = 8'($urandom);
         @(posedge clk); #1;
         if (vec_valid) got_q.push_back({dut_rst, dut_in, vec_idx});
         if (done) begin
            timed_out = 0;
            break;
         end
      end
      wr_en = 1'b0;
      n_vec++;
      if (timed_out != 0 || got_q.size() != 8) begin
         n_err++;
         $display("FAIL busy_write_count: got %0d (timeout %0d) expected 8", got_q.size(), timed_out);
      end
      do_start(8);
      play_collect(100, 0);
      for (int k = 0; k < 8; k++) begin
         n_vec++;
         if (k >= got_q.size() || got_q[k] !== {ref_mem[k], 5'(k)}) begin
            n_err++;
            $display("FAIL busy_write_vec%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 13'h0, {ref_mem[k], 5'(k)});
         end
      end
   endtask

`ifdef STIM_LFSR_EN
   task automatic test_lfsr;
      logic [15:0] s;
      logic [12:0] exp_q [$];
      exp_q.push_back({ref_mem[0], 5'd0});
      s = 16'hACE1;
      for (int j = 0; j < 4; j++) begin
         exp_q.push_back({1'b0, s[6:0], 5'(j + 1)});
         s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
      lfsr_seed   = 16'h0000;
      lfsr_cycles = 16'd4;
      do_start(1);
      lfsr_cycles = 16'd0;
      play_collect(50, 0);
      n_vec++;
      if (timed_out != 0 || got_q.size() != 5 || dut_rst !== 1'b1) begin
         n_err++;
         $display("FAIL lfsr_count: got %0d vectors (timeout %0d, dut_rst %b) expected 5", got_q.size(), timed_out, dut_rst);
      end
      for (int k = 0; k < 5 && k < got_q.size(); k++) begin
         n_vec++;
         if (got_q[k] !== exp_q[k]) begin
            n_err++;
            $display("FAIL lfsr_vec%0d: got %h expected %h", k, got_q[k], exp_q[k]);
         end
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      seq_len = '0;
      start   = 1'b0;
      pause   = 1'b0;
      abort   = 1'b0;
`ifdef STIM_LFSR_EN
      lfsr_seed   = 16'h0000;
      lfsr_cycles = 16'h0000;
`endif
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      #1;
      test_reset();
      test_basic();
      test_random_play();
      test_pause();
      test_abort();
      test_async_reset();
      test_zero_len_and_busy_write();
`ifdef STIM_LFSR_EN
      test_lfsr();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
